vme_bus_requester: RTL
======================

// Module: vme_bus_requester
// PURPOSE
//  Master-side VMEbus requester: gets bus ownership before vme_data_transfer may drive a cycle.
//  Runs BRn/BGnIN/BGnOUT/BBSY, passes foreign grants down the daisy chain, releases the bus.
//  Output bus_acquired feeds vme_data_transfer.bus_acquired.
//  Sits beside vme_data_transfer in the k30p VME interface CPLD.
// PARAMETERS
//  SYNC_STAGES         2  flops on async inputs vme_bgin, vme_bclr
//  BBSY_HOLD_CYCLES    5  min clocks vme_bbsy stays low once asserted (>=90 ns at 50 MHz)
//  RELEASE_ON_REQUEST  0  0 = release-when-done; 1 = hold bus until vme_bclr low
// PORTS
//  clock         in   1  system clock, all state on rising edge
//  reset         in   1  asynchronous, active-low reset
//  request_vme   in   1  active-low; current CPU cycle decodes to VME space
//  cpu_as        in   1  active-low CPU address strobe
//  vme_as        in   1  active-low VME AS as driven by vme_data_transfer
//  bus_acquired  out  1  active-low; bus owned, transfer may start
//  vme_br        out  1  active-low bus request (level selected by board jumper)
//  vme_bgin      in   1  active-low bus grant in (daisy chain, async)
//  vme_bgout     out  1  active-low bus grant out to next slot
//  vme_bbsy      out  1  active-low bus busy (open-drain driver external)
//  vme_bclr      in   1  active-low bus clear from arbiter (async)
// BEHAVIOUR
//  Reset (async, immediate): all outputs INACTIVE (1); state IDLE; hold counter 0.
//  Synchronised bgin_s, bclr_s: SYNC_STAGES cycle latency; FSM uses only those.
//  All outputs registered, no combinational in->out path.
//  States:
//   IDLE:    vme_bgout = bgin_s (pass-through). If request_vme=0 & cpu_as=0 & bgin_s=1
//            -> REQUEST. Request seen while bgin_s=0 waits in IDLE (never steal a grant
//            already passing downstream).
//   REQUEST: vme_br=0, vme_bgout=1. On bgin_s=0 -> OWNED: vme_bbsy=0, vme_br=1, load hold
//            counter. Request withdrawn (cpu_as=1) before grant: stay REQUEST, take grant,
//            release after min hold (VME forbids dropping BR before grant).
//   OWNED:   vme_bbsy=0, vme_bgout=1. bus_acquired=0 one cycle after vme_bbsy=0.
//            Counter decrements to 0, saturates. Release condition, all true same cycle:
//            counter=0 & cpu_as=1 & vme_as=1, plus:
//             RWD: request_vme=1.  ROR: bclr_s=0.
//            On release: bus_acquired=1 this edge -> RELEASE.
//   RELEASE: vme_bbsy=1 (one cycle after bus_acquired=1), vme_bgout=1.
//            -> IDLE only when bgin_s=1 (grant negated); no re-request before then.
//  A VME cycle in flight (vme_as=0) always blocks release, incl. bclr_s=0 in ROR mode.
//  ROR, OWNED, new request_vme=0 & cpu_as=0: bus_acquired stays 0, no re-arbitration.
//  bgin_s=0 in OWNED/RELEASE is our own grant; never forwarded.
//  Reset in OWNED: vme_bbsy and bus_acquired negate together, async; accepted.
//  Latency (SYNC_STAGES=2): request -> vme_br 1 clk; vme_bgin low -> vme_bbsy low 3 clk;
//   -> bus_acquired low 4 clk.
// STRUCTURE
//  vme_defs.vh (shared with vme_data_transfer): ACTIVE/INACTIVE, state encodings
//   REQ_IDLE/REQ_REQUEST/REQ_OWNED/REQ_RELEASE, RELEASE_* mode constants.
//  Sub-module vme_sync (N-stage sync, reset value 1), one per async input.
//  Hold counter $clog2(BBSY_HOLD_CYCLES+1) bits, unsigned.
// TESTING
//  1 RWD: request_vme=0,cpu_as=0 -> vme_br=0 next clk; vme_bgin=0 -> vme_bbsy=0 3 clk
//    later, vme_br=1, bus_acquired=0 1 clk after; cpu_as,request_vme=1 after 8 clk ->
//    bus_acquired=1, vme_bbsy=1 1 clk later, bgout stays 1.
//  2 Pass-through: idle, vme_bgin=0 -> vme_bgout=0 after 3 clk, vme_br stays 1; raise
//    request while grant passing -> no vme_br until vme_bgin=1 resynced.
//  3 Min hold: release condition true 1 clk after ownership -> vme_bbsy low exactly
//    BBSY_HOLD_CYCLES=5 clk.
//  4 Cycle in flight: vme_as=0 held 10 clk, release condition otherwise met -> vme_bbsy
//    stays 0 until 1 clk after vme_as=1; ROR with bclr low behaves same.
//  5 ROR: two back-to-back cpu_as cycles -> one BR/BBSY sequence, bus_acquired=0
//    throughout; vme_bclr=0 when idle -> bbsy=1 within SYNC_STAGES+2 clk.
//  6 Async reset in OWNED between edges -> all outputs 1 at once; after reset, IDLE,
//    new request needs fresh arbitration.

Source files
------------

// File: rtl/vme_bus_requester_pkg.sv
// Shared definitions for the VMEbus requester: signal polarity, release-mode
// selectors, requester state encoding and the bus-busy hold load helper.
package vme_bus_requester_pkg;

    // Every VME control line handled here is active-low.
    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    // Release policy selectors for the RELEASE_ON_REQUEST parameter.
    localparam bit RELEASE_WHEN_DONE = 1'b0;  // give the bus up as soon as the CPU is done
    localparam bit RELEASE_ON_REQ    = 1'b1;  // keep the bus until the arbiter asserts BCLR

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_REQUEST = 2'd1,
        REQ_OWNED   = 2'd2,
        REQ_RELEASE = 2'd3
    } req_state_e;

    // BBSY goes low on the ownership edge and rises one edge after the release
    // edge, so two clocks of every hold are structural. The counter only has
    // to cover the remainder for BBSY to stay low hold_cycles clocks minimum.
    function automatic int unsigned hold_load(input int unsigned hold_cycles);
        return (hold_cycles > 2) ? hold_cycles - 2 : 0;
    endfunction

endpackage

// File: rtl/vme_bus_requester_if.sv
// Bundle of the requester's CPU-side and VMEbus arbitration signals.
//   request_vme, cpu_as, vme_as : CPU / transfer-engine status (active-low)
//   vme_bgin, vme_bclr          : arbiter inputs, asynchronous (active-low)
//   bus_acquired                : ownership flag to vme_data_transfer (active-low)
//   vme_br, vme_bgout, vme_bbsy : arbitration outputs (active-low)
// master = the requester, slave = everything around it.
interface vme_bus_requester_if;
    logic request_vme;
    logic cpu_as;
    logic vme_as;
    logic bus_acquired;
    logic vme_br;
    logic vme_bgin;
    logic vme_bgout;
    logic vme_bbsy;
    logic vme_bclr;

    modport master (
        input  request_vme, cpu_as, vme_as, vme_bgin, vme_bclr,
        output bus_acquired, vme_br, vme_bgout, vme_bbsy
    );

    modport slave (
        output request_vme, cpu_as, vme_as, vme_bgin, vme_bclr,
        input  bus_acquired, vme_br, vme_bgout, vme_bbsy
    );
endinterface

// File: rtl/vme_bus_requester_sync.sv
// N-stage synchroniser for one asynchronous active-low VME input.
//   clock, reset : system clock, asynchronous active-low reset
//   d            : asynchronous input
//   q            : synchronised copy, STAGES clocks late, resets to 1 (inactive)
module vme_bus_requester_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: every flop of the chain is reset to the inactive level so no
    // phantom grant or clear can ripple out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= '1;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/vme_bus_requester.sv
// Master-side VMEbus requester. Wins bus ownership (BR/BGIN/BBSY) before the
// transfer engine may drive a cycle, forwards foreign grants down the daisy
// chain while idle and releases the bus when done (or on BCLR in ROR mode).
//   clock, reset : system clock, asynchronous active-low reset
//   bus (master) : request_vme, cpu_as, vme_as, vme_bgin, vme_bclr in;
//                  bus_acquired, vme_br, vme_bgout, vme_bbsy out (all registered)
module vme_bus_requester
    import vme_bus_requester_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned BBSY_HOLD_CYCLES   = 5,
    parameter bit          RELEASE_ON_REQUEST = RELEASE_WHEN_DONE
) (
    input logic                  clock,
    input logic                  reset,
    vme_bus_requester_if.master  bus
);

    localparam int unsigned     CNT_W     = $clog2(BBSY_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(hold_load(BBSY_HOLD_CYCLES));

    logic             bgin_s;
    logic             bclr_s;
    req_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             br_q, bgout_q, bbsy_q, acq_q;
    logic             br_d, bgout_d, bbsy_d, acq_d;
    logic             mode_ok;
    logic             release_ok;

    vme_bus_requester_sync #(.STAGES(SYNC_STAGES)) u_sync_bgin (
        .clock (clock),
        .reset (reset),
        .d     (bus.vme_bgin),
        .q     (bgin_s)
    );

    vme_bus_requester_sync #(.STAGES(SYNC_STAGES)) u_sync_bclr (
        .clock (clock),
        .reset (reset),
        .d     (bus.vme_bclr),
        .q     (bclr_s)
    );

    // A transfer in flight (vme_as low) always blocks release, in both modes.
    assign mode_ok = (RELEASE_ON_REQUEST == RELEASE_ON_REQ) ? (bclr_s == ACTIVE)
                                                            : (bus.request_vme == INACTIVE);
    assign release_ok = (hold_cnt_q == '0) && (bus.cpu_as == INACTIVE)
                     && (bus.vme_as == INACTIVE) && mode_ok;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= REQ_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // Never start a request while a foreign grant is passing through.
            REQ_IDLE:    if (bus.request_vme == ACTIVE && bus.cpu_as == ACTIVE && bgin_s == INACTIVE)
                             state_d = REQ_REQUEST;
            // BR may not be withdrawn before the grant; a dropped request
            // still takes the grant and releases after the minimum hold.
            REQ_REQUEST: if (bgin_s == ACTIVE) state_d = REQ_OWNED;
            REQ_OWNED:   if (release_ok) state_d = REQ_RELEASE;
            // Our own grant must be negated before another request is allowed.
            REQ_RELEASE: if (bgin_s == INACTIVE) state_d = REQ_IDLE;
            default:     state_d = REQ_IDLE;
        endcase
    end

    // Registered-output values are derived from the transition about to be
    // taken, so each output changes on the same edge as the state.
    always_comb begin
        br_d       = (state_d == REQ_REQUEST) ? ACTIVE : INACTIVE;
        bgout_d    = (state_q == REQ_IDLE && state_d == REQ_IDLE) ? bgin_s : INACTIVE;
        // BBSY also covers the release edge: it rises one clock after bus_acquired.
        bbsy_d     = (state_d == REQ_OWNED || state_q == REQ_OWNED) ? ACTIVE : INACTIVE;
        acq_d      = (state_q == REQ_OWNED && state_d == REQ_OWNED) ? ACTIVE : INACTIVE;
        hold_cnt_d = hold_cnt_q;
        if (state_q == REQ_REQUEST && state_d == REQ_OWNED) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (state_q == REQ_OWNED && hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_q    <= INACTIVE;
            bgout_q <= INACTIVE;
            bbsy_q  <= INACTIVE;
            acq_q   <= INACTIVE;
        end else begin
            br_q    <= br_d;
            bgout_q <= bgout_d;
            bbsy_q  <= bbsy_d;
            acq_q   <= acq_d;
        end
    end

    assign bus.vme_br       = br_q;
    assign bus.vme_bgout    = bgout_q;
    assign bus.vme_bbsy     = bbsy_q;
    assign bus.bus_acquired = acq_q;

endmodule
